// File: rtl/stb_gen_avg.sv
// stb_gen_avg: measures the averaged period of a comparator signal and free-runs a
// phase/width programmable strobe at that period, with timeout and settings errors.
module stb_gen_avg #(
  parameter int T_CNT_WIDTH  = 32,
  parameter int W_WIDTH      = 16,
  parameter int AVG_LOG2     = 2,
  parameter int SYNC_STAGES  = 2,
  parameter int TIMEOUT_CLKS = 2**20
) (
  input  logic                   clk_i,
  input  logic                   arst_ni,
  input  logic                   sig_i,
  input  logic                   run_det_i,
  input  logic [T_CNT_WIDTH-1:0] phase_i,
  input  logic [W_WIDTH-1:0]     width_i,
  input  logic                   oe_i,
  output logic                   stb_o,
  output logic                   rdy_o,
  output logic                   err_o,
  output logic [T_CNT_WIDTH-1:0] stb_period_o
);
  localparam int SW = T_CNT_WIDTH + AVG_LOG2;
  localparam logic [T_CNT_WIDTH-1:0] ONE     = T_CNT_WIDTH'(1);
  localparam logic [T_CNT_WIDTH-1:0] TWO     = T_CNT_WIDTH'(2);
  localparam logic [T_CNT_WIDTH-1:0] TO_LAST = T_CNT_WIDTH'(TIMEOUT_CLKS - 1);
  localparam logic [W_WIDTH-1:0]     W_ONE   = W_WIDTH'(1);
  localparam logic [AVG_LOG2:0]      NP_ONE  = (AVG_LOG2+1)'(1);
  localparam logic [AVG_LOG2:0]      NPER    = (AVG_LOG2+1)'(2**AVG_LOG2);

  typedef enum logic [1:0] {IDLE, ARM, MEAS, GEN} state_t;

  state_t                 state, state_n;
  logic [SYNC_STAGES-1:0] sync;
  logic                   prev, edg;
  logic [T_CNT_WIDTH-1:0] cnt, cnt_n, gcnt, gcnt_n, ph, ph_n, per_n, avg;
  logic [SW-1:0]          sum, sum_n, sum_edge;
  logic [AVG_LOG2:0]      npers, npers_n, npers_inc;
  logic [W_WIDTH-1:0]     wcnt, wcnt_n;
  logic                   stb_n, rdy_n, err_n, hit;

  // edg is registered: one pulse SYNC_STAGES+1 clocks after the sig_i rise
  always_ff @(posedge clk_i or negedge arst_ni)
    if (!arst_ni) begin
      sync <= '0;
      prev <= 1'b0;
      edg  <= 1'b0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], sig_i};
      prev <= sync[SYNC_STAGES-1];
      edg  <= sync[SYNC_STAGES-1] & ~prev;
    end

  assign sum_edge  = sum + SW'(cnt);
  assign avg       = T_CNT_WIDTH'(sum_edge >> AVG_LOG2);
  assign npers_inc = npers + NP_ONE;
  assign hit       = gcnt == ph;

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    sum_n   = sum;
    npers_n = npers;
    gcnt_n  = gcnt;
    wcnt_n  = wcnt;
    ph_n    = ph;
    per_n   = stb_period_o;
    rdy_n   = rdy_o;
    err_n   = err_o;
    stb_n   = 1'b0;
    if (run_det_i) begin
      state_n = ARM;
      cnt_n   = '0;
      sum_n   = '0;
      npers_n = '0;
      gcnt_n  = '0;
      wcnt_n  = '0;
      rdy_n   = 1'b0;
      err_n   = 1'b0;
    end else begin
      case (state)
        ARM, MEAS: begin
          if (edg && state == MEAS && npers_inc == NPER) begin
            if (avg < TWO || phase_i >= avg) begin
              state_n = IDLE;
              err_n   = 1'b1;
            end else begin
              state_n = GEN;
              per_n   = avg;
              rdy_n   = 1'b1;
              gcnt_n  = '0;
              wcnt_n  = '0;
              ph_n    = phase_i;
            end
          end else if (edg) begin
            state_n = MEAS;
            cnt_n   = ONE;
            sum_n   = (state == MEAS) ? sum_edge : sum;
            npers_n = (state == MEAS) ? npers_inc : npers;
          end else if (cnt == TO_LAST) begin
            state_n = IDLE;
            err_n   = 1'b1;
          end else
            cnt_n = cnt + ONE;
        end
        GEN: begin
          gcnt_n = (gcnt == stb_period_o - ONE) ? '0 : gcnt + ONE;
          wcnt_n = hit ? width_i : ((wcnt != '0) ? wcnt - W_ONE : '0);
          ph_n   = (hit && phase_i < stb_period_o) ? phase_i : ph;
          stb_n  = oe_i && wcnt_n != '0;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge arst_ni)
    if (!arst_ni) begin
      state        <= IDLE;
      cnt          <= '0;
      sum          <= '0;
      npers        <= '0;
      gcnt         <= '0;
      wcnt         <= '0;
      ph           <= '0;
      stb_o        <= 1'b0;
      rdy_o        <= 1'b0;
      err_o        <= 1'b0;
      stb_period_o <= '0;
    end else begin
      state        <= state_n;
      cnt          <= cnt_n;
      sum          <= sum_n;
      npers        <= npers_n;
      gcnt         <= gcnt_n;
      wcnt         <= wcnt_n;
      ph           <= ph_n;
      stb_o        <= stb_n;
      rdy_o        <= rdy_n;
      err_o        <= err_n;
      stb_period_o <= per_n;
    end
endmodule

// File: tb/tb_stb_gen_avg.sv
// tb_stb_gen_avg: randomized and directed stimulus for stb_gen_avg, checked every cycle
// against a period/phase arithmetic model plus hand-computed literal expectations.
module tb_stb_gen_avg;
  localparam int TW  = 32;
  localparam int WW  = 16;
  localparam int TO  = 1000;
  localparam int INF = 32'h7fffffff;

  logic          clk = 0, arst_n = 1, sig = 0, run_det = 0, oe = 1;
  logic [TW-1:0] phase = 0;
  logic [WW-1:0] width = 0;
  logic          stb, rdy, err;
  logic [TW-1:0] per;

  int cyc = 0, checks = 0, errors = 0;
  // model of the current segment: GEN starts at cycle m_g0 with period m_p if m_ok
  int m_ok = 0, m_g0 = INF, m_p = 0, m_ph = 0, m_w = 0, m_old = 0, m_err = INF;
  bit chk_on = 0;
  bit g, es;
  int x;
  longint t0, t1, t2;
  int n;

  stb_gen_avg #(.T_CNT_WIDTH(TW), .W_WIDTH(WW), .AVG_LOG2(2), .SYNC_STAGES(2),
                .TIMEOUT_CLKS(TO)) dut (
    .clk_i(clk), .arst_ni(arst_n), .sig_i(sig), .run_det_i(run_det), .phase_i(phase),
    .width_i(width), .oe_i(oe), .stb_o(stb), .rdy_o(rdy), .err_o(err), .stb_period_o(per)
  );

  always #4 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(string nm, longint act, longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      if (errors <= 40) $display("FAIL %s at cycle %0d: got %0d, expected %0d", nm, cyc, act, exp);
    end
  endfunction

  always begin
    @(posedge clk);
    #1;
    if (chk_on) begin
      g  = m_ok != 0 && cyc >= m_g0;
      x  = g ? cyc - m_g0 - m_ph - 1 : -1;
      es = g && oe && x >= 0 && (x % m_p) < m_w;
      chk("rdy", rdy, g);
      chk("stb", stb, es);
      chk("err", err, cyc >= m_err);
      chk("period", per, g ? m_p : m_old);
    end
  end

  task automatic segment(input int p0, p1, p2, p3, ph, w, hold);
    int r, n0, d0, d4, p;
    int pp[4];
    @(negedge clk);
    pp    = '{p0, p1, p2, p3};
    phase = TW'(ph);
    width = WW'(w);
    r     = cyc;
    n0    = r + 10;
    d0    = n0 + 3;
    d4    = d0 + p0 + p1 + p2 + p3;
    p     = (d4 - d0) / 4;
    if (m_ok != 0) m_old = m_p;
    m_ok  = (p >= 2 && ph < p) ? 1 : 0;
    m_p   = p;
    m_ph  = ph;
    m_w   = w;
    m_g0  = d4 + 1;
    m_err = (m_ok != 0) ? INF : d4 + 1;
    run_det = 1;
    @(negedge clk);
    run_det = 0;
    repeat (n0 - cyc) @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      sig = 1;
      repeat (i < 4 ? pp[i] / 2 : 20) @(negedge clk);
      sig = 0;
      if (i < 4) repeat (pp[i] - pp[i] / 2) @(negedge clk);
    end
    repeat (hold) @(negedge clk);
  endtask

  task automatic timeout_seg();
    int k;
    @(negedge clk);
    if (m_ok != 0) m_old = m_p;
    m_ok  = 0;
    m_g0  = INF;
    m_err = cyc + 1 + TO;
    run_det = 1;
    @(negedge clk);
    run_det = 0;
    k = 0;
    while (!err && k < TO + 100) begin
      @(negedge clk);
      k++;
    end
    chk("timeout_clks", k, TO);
    chk("timeout_rdy", rdy, 0);
  endtask

  task automatic next_rise(output longint t);
    bit p;
    p = stb;
    t = -1;
    for (int k = 0; k < 400; k++) begin
      @(negedge clk);
      if (stb && !p) begin
        t = $time;
        break;
      end
      p = stb;
    end
  endtask

  task automatic count_high(input int len, output int c);
    c = 0;
    for (int k = 0; k < len; k++) begin
      @(negedge clk);
      if (stb) c++;
    end
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    chk_on = 1;
    arst_n = 0;
    repeat (3) @(negedge clk);
    chk("reset_stb", stb, 0);
    chk("reset_rdy", rdy, 0);
    chk("reset_err", err, 0);
    chk("reset_period", per, 0);
    arst_n = 1;
    repeat (5) @(negedge clk);

    segment(125, 125, 125, 125, 10, 3, 30);
    chk("basic_period", per, 125);
    chk("basic_rdy", rdy, 1);
    next_rise(t1);
    next_rise(t2);
    chk("basic_spacing_ns", t2 - t1, 1000);
    count_high(125, n);
    chk("basic_width", n, 3);

    segment(124, 126, 125, 125, 10, 3, 20);
    chk("jitter_period", per, 125);
    segment(125, 125, 125, 126, 10, 3, 20);
    chk("trunc_period", per, 125);
    segment(127, 127, 127, 126, 10, 3, 20);
    chk("trunc_period_126", per, 126);

    segment(125, 125, 125, 125, 123, 5, 20);
    count_high(125, n);
    chk("wrap_width", n, 5);
    segment(125, 125, 125, 125, 10, 200, 300);
    count_high(125, n);
    chk("continuous_high", n, 125);

    segment(125, 125, 125, 125, 200, 3, 200);
    chk("phase_err", err, 1);
    chk("phase_rdy", rdy, 0);
    chk("phase_period_held", per, 125);

    timeout_seg();
    segment(125, 125, 125, 125, 10, 3, 200);
    chk("err_cleared", err, 0);
    chk("rerun_rdy", rdy, 1);

    next_rise(t0);
    oe = 0;
    count_high(300, n);
    chk("oe_off_high", n, 0);
    oe = 1;
    next_rise(t1);
    next_rise(t2);
    chk("oe_spacing_ns", t2 - t1, 1000);
    chk("oe_coherent", (t1 - t0) % 1000, 0);

    for (int it = 0; it < 6; it++) begin
      int b, ph, w;
      b  = $urandom_range(60, 180);
      ph = $urandom_range(0, b + 10);
      w  = $urandom_range(0, b + 20);
      segment(b + $urandom_range(0, 4) - 2, b + $urandom_range(0, 4) - 2,
              b + $urandom_range(0, 4) - 2, b + $urandom_range(0, 4) - 2, ph, w, 0);
      for (int k = 0; k < 400; k++) begin
        @(negedge clk);
        if ($urandom_range(0, 49) == 0) oe = ~oe;
      end
      oe = 1;
    end

    segment(125, 125, 125, 125, 10, 20, 130);
    next_rise(t0);
    #1;
    arst_n = 0;
    m_ok  = 0;
    m_old = 0;
    m_err = INF;
    m_g0  = INF;
    #1;
    chk("async_rst_stb", stb, 0);
    chk("async_rst_rdy", rdy, 0);
    chk("async_rst_period", per, 0);
    repeat (2) @(negedge clk);
    arst_n = 1;
    count_high(300, n);
    chk("post_rst_high", n, 0);
    chk("post_rst_rdy", rdy, 0);

    chk_on = 0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/stb_gen_avg.md
Name: stb_gen_avg

Overview:
Parametrised successor to the single-shot strobe generator. It measures the period of an asynchronous comparator signal, averaging over 2^AVG_LOG2 consecutive periods. It then free-runs a strobe at that averaged period, with a programmable phase offset and pulse width relative to the last detected edge. It sits between the comparator front-end and the measure-unit sampling logic, and adds error reporting for timeouts and bad settings.

Parameters:
T_CNT_WIDTH, 32, width of the period counter and of stb_period_o/phase_i.
W_WIDTH, 16, width of width_i (strobe width in clocks).
AVG_LOG2, 2, log2 of the number of periods averaged (0 = single period).
SYNC_STAGES, 2, synchroniser depth on sig_i (>=2).
TIMEOUT_CLKS, 2**20, maximum clocks allowed between edges in ARM/MEAS.

Ports:
clk_i  in  1  system clock
arst_ni  in  1  asynchronous active-low reset
sig_i  in  1  asynchronous comparator output; rising edges are measured
run_det_i  in  1  start (or restart) measurement; sampled high in any state
phase_i  in  T_CNT_WIDTH  strobe delay in clocks after the edge-aligned count 0
width_i  in  W_WIDTH  strobe high time in clocks; 0 = no strobe
oe_i  in  1  strobe output enable
stb_o  out  1  generated strobe
rdy_o  out  1  averaged period valid, generator running
err_o  out  1  sticky error flag
stb_period_o  out  T_CNT_WIDTH  averaged period in clocks

Behaviour:
- Reset (arst_ni=0, async): state IDLE; stb_o=0, rdy_o=0, err_o=0, stb_period_o=0; all counters 0.
- sig_i passes through a SYNC_STAGES flop synchroniser. A rising-edge detect then produces a 1-cycle edge pulse, with latency SYNC_STAGES+1 clocks from the sig_i rise.
- States: IDLE, ARM, MEAS, GEN.
- IDLE: on run_det_i=1 -> ARM. Clear err_o, rdy_o and the accumulator.
- ARM: wait for the first edge; cnt runs from 0.
  - Edge -> MEAS, cnt=1.
  - cnt reaches TIMEOUT_CLKS -> err_o=1, IDLE.
- MEAS: cnt increments each clock.
  - On each edge: sum += cnt, cnt restarts at 1, npers++.
  - When npers reaches 2^AVG_LOG2 (same edge): period = sum >> AVG_LOG2 (truncating). stb_period_o=period, rdy_o=1 next cycle, enter GEN. The generator counter gcnt=0 in the cycle after that edge, which is the edge-aligned cycle.
  - sum is T_CNT_WIDTH+AVG_LOG2 bits wide; no overflow is possible.
  - Timeout -> err_o=1, IDLE.
- Entry checks on the final edge, in priority order (the first match sets err_o=1, rdy_o stays 0, state -> IDLE):
  - period < 2.
  - phase_i >= period.
- GEN: gcnt counts 0..period-1 and wraps to 0.
  - At gcnt==phase_i, a width down-counter loads width_i.
  - stb_o is registered and is 1 while the width counter is nonzero, so it rises exactly phase_i+1 clocks after gcnt=0.
  - The strobe may straddle the wrap.
  - width_i >= period gives a continuous high: the reload occurs before expiry.
- phase_i/width_i are sampled at each gcnt==phase_i event; changes take effect at the next period.
- oe_i=0 forces stb_o=0. gcnt and the width counter keep running, so re-enable is phase-coherent.
- GEN does not track sig_i; drift is corrected only by re-issuing run_det_i.
- run_det_i=1 in ARM/MEAS/GEN: stb_o=0 and rdy_o=0 next cycle; restart in ARM with err_o cleared. run_det_i takes priority over a simultaneous edge.
- err_o holds until run_det_i or reset. stb_period_o holds its last valid value until the next successful measurement.
- Reset mid-operation returns everything to the reset values immediately.

Test Plan:
- CLK 8 ns, AVG_LOG2=2, sig period 1000 ns (125 clks), phase_i=10, width_i=3 -> stb_period_o=125, rdy_o=1; stb_o high 3 clks every 125 clks; measured strobe period 1000 ns.
- Jittered periods 124,126,125,125 clks -> sum 500 -> stb_period_o=125. Periods 125,125,125,126 -> 501>>2 = 125 (truncation).
- Wrap: period 125, phase_i=123, width_i=5 -> stb_o high at gcnt 124,0,1,2,3. width_i=200 -> stb_o constant 1.
- No sig_i edges after run_det_i, TIMEOUT_CLKS=1000 -> err_o=1 exactly 1000 clks after entering ARM; rdy_o=0; the next run_det_i clears err_o.
- phase_i=200 with a 125-clk period -> err_o=1, rdy_o=0, stb_o never pulses.
- oe_i 1->0->1 in GEN -> stb_o low while disabled; after re-enable, pulse spacing is still 125 clks. arst_ni low mid-GEN -> all outputs 0 asynchronously, no strobe until a new run_det_i.
